// File: rtl/rf_access_ctrl.sv
// Register-file access controller: issue-side hazard scoreboard, operand read
// strobes, and a round-robin ALU/LSU writeback arbiter feeding one write port.
module rf_access_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            i_issue_valid,
    output logic            o_issue_ready,
    input  logic [4:0]      i_issue_rs1,
    input  logic [4:0]      i_issue_rs2,
    input  logic [4:0]      i_issue_rd,
    input  logic            i_issue_rd_en,

    output logic            o_rs_ren,
    output logic [4:0]      o_rs1_raddr,
    output logic [4:0]      o_rs2_raddr,
    output logic            o_operands_valid,

    input  logic            i_alu_wb_valid,
    output logic            o_alu_wb_ready,
    input  logic [4:0]      i_alu_wb_addr,
    input  logic [XLEN-1:0] i_alu_wb_data,

    input  logic            i_lsu_wb_valid,
    output logic            o_lsu_wb_ready,
    input  logic [4:0]      i_lsu_wb_addr,
    input  logic [XLEN-1:0] i_lsu_wb_data,

    output logic            o_rd_wvalid,
    output logic [4:0]      o_rd_waddr,
    output logic [XLEN-1:0] o_rd_wdata,

    output logic [31:0]     o_busy,
    output logic            o_wb_err
);

    logic            ptr_lsu;
    logic            grant_alu;
    logic            grant_lsu;
    logic            grant_any;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     busy_set;
    logic [31:0]     busy_clr;
    logic [31:0]     busy_next;

    // Hazard check looks only at registered busy bits, so writeback inputs
    // never reach o_issue_ready combinationally.
    assign o_issue_ready = !o_busy[i_issue_rs1] && !o_busy[i_issue_rs2]
                         && !(i_issue_rd_en && o_busy[i_issue_rd]);
    assign o_rs_ren      = i_issue_valid && o_issue_ready;
    assign o_rs1_raddr   = i_issue_rs1;
    assign o_rs2_raddr   = i_issue_rs2;

    always_comb begin
        grant_alu = rstn && i_alu_wb_valid && (!i_lsu_wb_valid || !ptr_lsu);
        grant_lsu = rstn && i_lsu_wb_valid && (!i_alu_wb_valid || ptr_lsu);
        grant_any = grant_alu || grant_lsu;
        wb_addr   = grant_lsu ? i_lsu_wb_addr : i_alu_wb_addr;
        wb_data   = grant_lsu ? i_lsu_wb_data : i_alu_wb_data;
    end

    assign o_alu_wb_ready = grant_alu;
    assign o_lsu_wb_ready = grant_lsu;

    // Clear follows the registered write port; set is applied last so it wins.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (o_rs_ren && i_issue_rd_en && (i_issue_rd != 5'd0))
            busy_set = 32'd1 << i_issue_rd;
        if (o_rd_wvalid)
            busy_clr = 32'd1 << o_rd_waddr;
        busy_next = ((o_busy & ~busy_clr) | busy_set) & ~32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_busy           <= '0;
            o_rd_wvalid      <= 1'b0;
            o_rd_waddr       <= '0;
            o_rd_wdata       <= '0;
            o_operands_valid <= 1'b0;
            o_wb_err         <= 1'b0;
            ptr_lsu          <= 1'b0;
        end else begin
            o_busy           <= busy_next;
            o_operands_valid <= o_rs_ren;
            o_rd_wvalid      <= grant_any && (wb_addr != 5'd0);
            o_wb_err         <= grant_any && (wb_addr != 5'd0) && !o_busy[wb_addr];
            if (grant_any) begin
                o_rd_waddr <= wb_addr;
                o_rd_wdata <= wb_data;
            end
            if (i_alu_wb_valid && i_lsu_wb_valid)
                ptr_lsu <= !ptr_lsu;
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Self-checking bench for rf_access_ctrl: vector table with a queue of
// next-cycle expectations, plus a hand-written reset-mid-operation sequence.
module tb_rf_access_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic            i_issue_valid;
    logic            o_issue_ready;
    logic [4:0]      i_issue_rs1, i_issue_rs2, i_issue_rd;
    logic            i_issue_rd_en;
    logic            o_rs_ren;
    logic [4:0]      o_rs1_raddr, o_rs2_raddr;
    logic            o_operands_valid;
    logic            i_alu_wb_valid, o_alu_wb_ready;
    logic [4:0]      i_alu_wb_addr;
    logic [XLEN-1:0] i_alu_wb_data;
    logic            i_lsu_wb_valid, o_lsu_wb_ready;
    logic [4:0]      i_lsu_wb_addr;
    logic [XLEN-1:0] i_lsu_wb_data;
    logic            o_rd_wvalid;
    logic [4:0]      o_rd_waddr;
    logic [XLEN-1:0] o_rd_wdata;
    logic [31:0]     o_busy;
    logic            o_wb_err;

    rf_access_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rstn(rstn),
        .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready),
        .i_issue_rs1(i_issue_rs1), .i_issue_rs2(i_issue_rs2),
        .i_issue_rd(i_issue_rd), .i_issue_rd_en(i_issue_rd_en),
        .o_rs_ren(o_rs_ren), .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr),
        .o_operands_valid(o_operands_valid),
        .i_alu_wb_valid(i_alu_wb_valid), .o_alu_wb_ready(o_alu_wb_ready),
        .i_alu_wb_addr(i_alu_wb_addr), .i_alu_wb_data(i_alu_wb_data),
        .i_lsu_wb_valid(i_lsu_wb_valid), .o_lsu_wb_ready(o_lsu_wb_ready),
        .i_lsu_wb_addr(i_lsu_wb_addr), .i_lsu_wb_data(i_lsu_wb_data),
        .o_rd_wvalid(o_rd_wvalid), .o_rd_waddr(o_rd_waddr), .o_rd_wdata(o_rd_wdata),
        .o_busy(o_busy), .o_wb_err(o_wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rs1, rs2, rd;
        logic        en;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_ir, e_ar, e_lr;
        logic        e_opv, e_wv;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_err;
        logic [31:0] e_busy;
    } vec_t;

    typedef struct {
        logic        opv, wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        err;
        logic [31:0] busy;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        i_issue_valid = 0; i_issue_rs1 = 0; i_issue_rs2 = 0; i_issue_rd = 0; i_issue_rd_en = 0;
        i_alu_wb_valid = 0; i_alu_wb_addr = 0; i_alu_wb_data = 0;
        i_lsu_wb_valid = 0; i_lsu_wb_addr = 0; i_lsu_wb_data = 0;
    endtask

    task automatic check_regs(input string tag, input exp_t e);
        chk({tag, ".opv"},  32'(o_operands_valid), 32'(e.opv));
        chk({tag, ".wv"},   32'(o_rd_wvalid),      32'(e.wv));
        chk({tag, ".wa"},   32'(o_rd_waddr),       32'(e.wa));
        chk({tag, ".wd"},   o_rd_wdata,            e.wd);
        chk({tag, ".err"},  32'(o_wb_err),         32'(e.err));
        chk({tag, ".busy"}, o_busy,                e.busy);
    endtask

    initial begin
        exp_t e;
        // iv rs1 rs2 rd en | av aa ad | lv la ld | ir ar lr | opv wv wa wd err busy
        vecs[0]  = '{1, 1, 2, 5, 1,  0, 0, 0,       0, 0, 0,       1, 0, 0,  1, 0, 0, 0,       0, 32'h20};
        vecs[1]  = '{1, 5, 0, 0, 0,  1, 5, 'hDEAD,  0, 0, 0,       0, 1, 0,  0, 1, 5, 'hDEAD,  0, 32'h20};
        vecs[2]  = '{1, 5, 0, 0, 0,  0, 0, 0,       0, 0, 0,       0, 0, 0,  0, 0, 5, 'hDEAD,  0, 32'h0};
        vecs[3]  = '{1, 5, 6, 7, 1,  0, 0, 0,       0, 0, 0,       1, 0, 0,  1, 0, 5, 'hDEAD,  0, 32'h80};
        vecs[4]  = '{1, 3, 4, 8, 1,  1, 7, 'h1111,  1, 8, 'h2222,  1, 1, 0,  1, 1, 7, 'h1111,  0, 32'h180};
        vecs[5]  = '{0, 0, 0, 0, 0,  1, 9, 'h3333,  1, 8, 'h2222,  1, 0, 1,  0, 1, 8, 'h2222,  0, 32'h100};
        vecs[6]  = '{0, 0, 0, 0, 0,  1, 9, 'h3333,  1, 10, 'h4444, 1, 1, 0,  0, 1, 9, 'h3333,  1, 32'h0};
        vecs[7]  = '{0, 0, 0, 0, 0,  0, 0, 0,       1, 0, 'h5555,  1, 0, 1,  0, 0, 0, 'h5555,  0, 32'h0};
        vecs[8]  = '{0, 0, 0, 0, 0,  1, 7, 'h7777,  0, 0, 0,       1, 1, 0,  0, 1, 7, 'h7777,  1, 32'h0};
        vecs[9]  = '{0, 0, 0, 0, 0,  1, 1, 'hA,     1, 2, 'hB,     1, 0, 1,  0, 1, 2, 'hB,     1, 32'h0};
        vecs[10] = '{1, 0, 0, 0, 1,  0, 0, 0,       0, 0, 0,       1, 0, 0,  1, 0, 2, 'hB,     0, 32'h0};

        idle_inputs();
        rstn = 0;
        i_alu_wb_valid = 1; i_alu_wb_addr = 3;
        @(negedge clk);
        #1 chk("rst.alu_ready", 32'(o_alu_wb_ready), 0);
        @(negedge clk);
        idle_inputs();
        rstn = 1;
        e = '{0, 0, 0, 0, 0, 0};
        check_regs("reset", e);

        for (int i = 0; i < 11; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (sb.size() == 0) chk($sformatf("v%0d.sb_empty", i), 1, 0);
                else check_regs($sformatf("v%0d", i - 1), sb.pop_front());
            end
            i_issue_valid = vecs[i].iv;  i_issue_rs1 = vecs[i].rs1;
            i_issue_rs2 = vecs[i].rs2;   i_issue_rd = vecs[i].rd;  i_issue_rd_en = vecs[i].en;
            i_alu_wb_valid = vecs[i].av; i_alu_wb_addr = vecs[i].aa; i_alu_wb_data = vecs[i].ad;
            i_lsu_wb_valid = vecs[i].lv; i_lsu_wb_addr = vecs[i].la; i_lsu_wb_data = vecs[i].ld;
            #1;
            chk($sformatf("v%0d.issue_ready", i), 32'(o_issue_ready), 32'(vecs[i].e_ir));
            chk($sformatf("v%0d.rs_ren", i), 32'(o_rs_ren), 32'(vecs[i].e_ir && vecs[i].iv));
            chk($sformatf("v%0d.rs1_raddr", i), 32'(o_rs1_raddr), 32'(vecs[i].rs1));
            chk($sformatf("v%0d.alu_ready", i), 32'(o_alu_wb_ready), 32'(vecs[i].e_ar));
            chk($sformatf("v%0d.lsu_ready", i), 32'(o_lsu_wb_ready), 32'(vecs[i].e_lr));
            sb.push_back('{vecs[i].e_opv, vecs[i].e_wv, vecs[i].e_wa, vecs[i].e_wd,
                           vecs[i].e_err, vecs[i].e_busy});
        end
        @(negedge clk);
        idle_inputs();
        if (sb.size() == 0) chk("v10.sb_empty", 1, 0);
        else check_regs("v10", sb.pop_front());

        // Fill x4..x7, flip the pointer with a contended grant, then reset.
        for (int r = 4; r < 8; r++) begin
            i_issue_valid = 1; i_issue_rd = 5'(r); i_issue_rd_en = 1;
            @(negedge clk);
        end
        idle_inputs();
        chk("seq.busy_f0", o_busy, 32'h0000_00F0);
        i_alu_wb_valid = 1; i_alu_wb_addr = 4; i_alu_wb_data = 'h44;
        i_lsu_wb_valid = 1; i_lsu_wb_addr = 5; i_lsu_wb_data = 'h55;
        #1 chk("seq.alu_first", 32'(o_alu_wb_ready), 1);
        @(negedge clk);
        chk("seq.wv_pending", 32'(o_rd_wvalid), 1);
        rstn = 0;
        #1;
        chk("seq.rst_alu_ready", 32'(o_alu_wb_ready), 0);
        chk("seq.rst_lsu_ready", 32'(o_lsu_wb_ready), 0);
        @(negedge clk);
        rstn = 1;
        e = '{0, 0, 0, 0, 0, 0};
        check_regs("seq.after_rst", e);
        #1;
        chk("seq.ptr_alu", 32'(o_alu_wb_ready), 1);
        chk("seq.ptr_lsu", 32'(o_lsu_wb_ready), 0);
        @(negedge clk);
        idle_inputs();
        chk("seq.err_after_rst", 32'(o_wb_err), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
